sddac_interp: RTL and testbench

- Linear-interpolating upsampler that sits directly upstream of the sigma-delta modulator's 48-bit DSP adder stage.
- Accepts signed audio samples at the low sample rate over a valid/ready handshake.
- On every modulator tick, emits one interpolated value, sign-extended to 48 bits, which drives the adder's data operand.
- Ramps linearly from the previous sample to the current one over 2^OSR_LOG2 ticks, removing zero-order-hold images before noise shaping.

---
 rtl/sddac_pkg.sv | 19 +
 rtl/sddac_interp_if.sv | 26 ++
 rtl/sddac_sample_buf.sv | 47 ++++
 rtl/sddac_interp.sv | 144 ++++++++++++++
 tb/tb_sddac_interp.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sddac_pkg.sv
// Shared types and constants for the sigma-delta interpolating upsampler.
package sddac_pkg;

  localparam int DEF_DATA_W   = 18;
  localparam int DEF_OSR_LOG2 = 6;
  localparam int DEF_OUT_W    = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // One guard bit above sample * 2^osr_log2 so a full ramp never overflows.
  function automatic int acc_width(input int data_w, input int osr_log2);
    return data_w + osr_log2 + 1;
  endfunction

endpackage

// File: rtl/sddac_interp_if.sv
// Sample-in / modulator-out bundle of the interpolating upsampler.
interface sddac_interp_if #(
  parameter int DATA_W = 18,
  parameter int OUT_W  = 48
) ();

  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic                     sample_ready;
  logic                     mod_tick;
  logic signed [OUT_W-1:0]  interp_out;
  logic                     interp_valid;
  logic                     underrun;
  logic                     running;

  modport master (
    output sample_in, sample_valid, mod_tick,
    input  sample_ready, interp_out, interp_valid, underrun, running
  );

  modport slave (
    input  sample_in, sample_valid, mod_tick,
    output sample_ready, interp_out, interp_valid, underrun, running
  );

endinterface

// File: rtl/sddac_sample_buf.sv
// One-deep input holding register; ready whenever it is empty.
module sddac_sample_buf
  import sddac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] pend_data,
  output logic              pend_valid
);

  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              pend_valid_q, pend_valid_d;

  assign in_ready   = ~pend_valid_q;
  assign pend_data  = pend_data_q;
  assign pend_valid = pend_valid_q;

  // A pop only happens while full and a load only while empty, so they never collide.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    if (pop) begin
      pend_valid_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      pend_data_d  = in_data;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: rtl/sddac_interp.sv
// Linear-interpolating upsampler: ramps prev -> cur over 2^OSR_LOG2 modulator
// ticks and presents the accumulator sign-extended to the adder operand width.
module sddac_interp
  import sddac_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OSR_LOG2 = DEF_OSR_LOG2,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  logic           clk,
  input  logic           reset,
  sddac_interp_if.slave  bus
);

  localparam int ACC_W = acc_width(DATA_W, OSR_LOG2);

  logic                     pop;
  logic                     pend_valid;
  logic        [DATA_W-1:0] pend_raw;
  logic signed [DATA_W-1:0] pend_data;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic signed [DATA_W-1:0] cur_q, cur_d;
  logic signed [DATA_W:0]   delta_q, delta_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OSR_LOG2-1:0]      phase_q, phase_d;
  logic signed [OUT_W-1:0]  interp_out_q, interp_out_d;
  logic                     interp_valid_q, interp_valid_d;
  logic                     underrun_q, underrun_d;
  logic                     running_q, running_d;

  sddac_sample_buf #(.DATA_W(DATA_W)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .in_data    (bus.sample_in),
    .in_valid   (bus.sample_valid),
    .in_ready   (bus.sample_ready),
    .pop        (pop),
    .pend_data  (pend_raw),
    .pend_valid (pend_valid)
  );

  assign pend_data        = pend_raw;
  assign bus.interp_out   = interp_out_q;
  assign bus.interp_valid = interp_valid_q;
  assign bus.underrun     = underrun_q;
  assign bus.running      = running_q;

  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    cur_d          = cur_q;
    acc_d          = acc_q;
    phase_d        = phase_q;
    interp_out_d   = interp_out_q;
    interp_valid_d = 1'b0;
    underrun_d     = 1'b0;
    pop            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.mod_tick) begin
          interp_out_d   = '0;
          interp_valid_d = 1'b1;
        end
        if (pend_valid) begin
          prev_d  = '0;
          cur_d   = pend_data;
          phase_d = '0;
          pop     = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.mod_tick) begin
          acc_d          = acc_q + ACC_W'(delta_q);
          phase_d        = phase_q + OSR_LOG2'(1);
          interp_out_d   = OUT_W'(acc_d);
          interp_valid_d = 1'b1;
          if (phase_q == '1) begin
            // acc has landed exactly on cur << OSR_LOG2; chain or hold there.
            prev_d = cur_q;
            if (pend_valid) begin
              cur_d = pend_data;
              pop   = 1'b1;
            end else begin
              state_d    = ST_HOLD;
              underrun_d = 1'b1;
            end
          end
        end
      end

      ST_HOLD: begin
        if (bus.mod_tick) begin
          interp_out_d   = OUT_W'(acc_q);
          interp_valid_d = 1'b1;
        end
        if (pend_valid) begin
          prev_d  = cur_q;
          cur_d   = pend_data;
          phase_d = '0;
          pop     = 1'b1;
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // With prev pulled up to cur on entering HOLD, delta reads zero there.
    delta_d   = (DATA_W+1)'(cur_d) - (DATA_W+1)'(prev_d);
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      prev_q         <= '0;
      cur_q          <= '0;
      delta_q        <= '0;
      acc_q          <= '0;
      phase_q        <= '0;
      interp_out_q   <= '0;
      interp_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      cur_q          <= cur_d;
      delta_q        <= delta_d;
      acc_q          <= acc_d;
      phase_q        <= phase_d;
      interp_out_q   <= interp_out_d;
      interp_valid_q <= interp_valid_d;
      underrun_q     <= underrun_d;
      running_q      <= running_d;
    end
  end

endmodule

// File: tb/tb_sddac_interp.sv
// Bench for sddac_interp at OSR_LOG2=2: ramp-equation model checked every
// cycle, plus literal ramp values from hand calculation.
module tb_sddac_interp;

  localparam int DATA_W = 18;
  localparam int OSR    = 2;
  localparam int OUT_W  = 48;
  localparam int N      = 1 << OSR;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sddac_interp_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus_if ();

  sddac_interp #(.DATA_W(DATA_W), .OSR_LOG2(OSR), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a ramp is prev*N + (cur-prev)*k after k ticks; holds sit at cur*N.
  int     m_mode = 0;  // 0 idle, 1 ramping, 2 holding
  longint m_prev = 0, m_cur = 0, m_pend = 0, m_sin = 0;
  int     m_k = 0;
  bit     m_pv = 0, m_take = 0;
  bit     e_valid = 0, e_under = 0;
  longint e_out = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_prev = 0; m_cur = 0; m_pend = 0; m_k = 0; m_pv = 0;
      e_valid = 0; e_under = 0; e_out = 0;
    end else begin
      m_take  = bus_if.sample_valid && !m_pv;
      m_sin   = longint'(bus_if.sample_in);
      e_valid = 0;
      e_under = 0;
      case (m_mode)
        0: begin
          if (bus_if.mod_tick) begin e_valid = 1; e_out = 0; end
          if (m_pv) begin m_prev = 0; m_cur = m_pend; m_k = 0; m_pv = 0; m_mode = 1; end
        end
        1: begin
          if (bus_if.mod_tick) begin
            m_k++;
            e_valid = 1;
            e_out   = m_prev * N + (m_cur - m_prev) * m_k;
            if (m_k == N) begin
              if (m_pv) begin m_prev = m_cur; m_cur = m_pend; m_k = 0; m_pv = 0; end
              else begin m_mode = 2; e_under = 1; end
            end
          end
        end
        default: begin
          if (bus_if.mod_tick) begin e_valid = 1; e_out = m_cur * N; end
          if (m_pv) begin m_prev = m_cur; m_cur = m_pend; m_k = 0; m_pv = 0; m_mode = 1; end
        end
      endcase
      if (m_take) begin m_pend = m_sin; m_pv = 1; end
    end
  end

  always @(negedge clk) begin
    chk("valid", bus_if.interp_valid, e_valid);
    chk("underrun", bus_if.underrun, e_under);
    chk("running", bus_if.running, m_mode == 1);
    chk("ready", bus_if.sample_ready, !m_pv);
    if (e_valid) chk("out", bus_if.interp_out, e_out);
  end

  task automatic tick();
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus_if.mod_tick = 1'b1;
    @(posedge clk); #1;
    bus_if.mod_tick = 1'b0;
  endtask

  task automatic tick_exp(input string name, input longint v);
    tick();
    chk(name, bus_if.interp_out, v);
    chk({name, "_valid"}, bus_if.interp_valid, 1);
  endtask

  task automatic push(input int v);
    int n = 0;
    bus_if.sample_in    = DATA_W'(v);
    bus_if.sample_valid = 1'b1;
    while (!bus_if.sample_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("push_wait_bound", n >= 100, 0);
    @(posedge clk); #1;
    bus_if.sample_valid = 1'b0;
    $display("push sample %0d", v);
  endtask

  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1;
    chk("rst_out", bus_if.interp_out, 0);
    chk("rst_running", bus_if.running, 0);
    chk("rst_valid", bus_if.interp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("rel_ready", bus_if.sample_ready, 1);
    chk("rel_running", bus_if.running, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset               = 1'b0;
    bus_if.sample_in    = '0;
    bus_if.sample_valid = 1'b0;
    bus_if.mod_tick     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_out", bus_if.interp_out, 0);
    reset = 1'b1;
    chk("init_ready", bus_if.sample_ready, 1);

    // Idle ticks produce zeros.
    for (int i = 0; i < 4; i++) begin
      tick_exp("s1_tick", 0);
      chk("s1_running", bus_if.running, 0);
    end

    // Chained ramps 0 -> 100 -> 200 -> -100.
    push(100);
    push(200);
    for (int i = 1; i <= 6; i++) tick_exp("s2_tick", 100 * i);
    push(-100);
    tick_exp("s2_tick7", 700);
    tick_exp("s2_tick8", 800);
    chk("s2_no_underrun", bus_if.underrun, 0);
    tick_exp("s3_tick1", 500);
    tick_exp("s3_tick2", 200);
    tick_exp("s3_tick3", -100);
    tick_exp("s3_tick4", -400);
    begin
      logic [47:0] raw;
      raw = bus_if.interp_out;
      chk("s3_hex", {16'd0, raw}, 64'h0000_FFFF_FFFF_FE70);
    end
    chk("s3_underrun", bus_if.underrun, 1);

    // Single sample, underrun into hold, then resume from the held level.
    reset_pulse();
    push(50);
    tick_exp("s4_t1", 50);
    tick_exp("s4_t2", 100);
    tick_exp("s4_t3", 150);
    tick_exp("s4_t4", 200);
    chk("s4_underrun", bus_if.underrun, 1);
    tick_exp("s4_t5", 200);
    tick_exp("s4_t6", 200);
    push(0);
    tick_exp("s4_r1", 150);
    tick_exp("s4_r2", 100);
    tick_exp("s4_r3", 50);
    tick_exp("s4_r4", 0);

    // Continuous valid with random ticks and samples.
    reset_pulse();
    bus_if.sample_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus_if.sample_in = DATA_W'($urandom);
      bus_if.mod_tick  = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    bus_if.sample_valid = 1'b0;
    bus_if.mod_tick     = 1'b0;

    // Sparse random traffic, including extreme sample values.
    for (int i = 0; i < 400; i++) begin
      bus_if.sample_valid = ($urandom_range(0, 9) < 2);
      case ($urandom_range(0, 3))
        0:       bus_if.sample_in = 18'sh1FFFF;
        1:       bus_if.sample_in = 18'sh20000;
        default: bus_if.sample_in = DATA_W'($urandom);
      endcase
      bus_if.mod_tick = ($urandom_range(0, 9) < 4);
      @(posedge clk); #1;
    end
    bus_if.sample_valid = 1'b0;
    bus_if.mod_tick     = 1'b0;

    // Reset in the middle of a ramp.
    reset_pulse();
    push(100);
    tick_exp("s6_t1", 100);
    tick_exp("s6_t2", 200);
    reset_pulse();
    tick_exp("s6_idle", 0);
    chk("s6_running", bus_if.running, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
